// File: rtl/dlx_pkg.sv
// dlx_pkg: shared definitions for the DLX instruction-fetch slice.
//   - WORD_W          : datapath / address width
//   - OP_*            : primary opcode values (instr[31:26]) of the control-flow instructions
//   - fetch_state_t   : fetch-stage FSM state encoding
// Optional feature macro: DLX_IFETCH_ALIGN_CHECK_EN adds the ERR state.
package dlx_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQZ = 6'd4;
  localparam logic [5:0] OP_BNEZ = 6'd5;
  localparam logic [5:0] OP_JR   = 6'd18;
  localparam logic [5:0] OP_JALR = 6'd19;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1
`ifdef DLX_IFETCH_ALIGN_CHECK_EN
    ,
    ST_ERR   = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/dlx_next_pc.sv
// dlx_next_pc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4   in  32  sequential successor of the held instruction
//   instr_imm  in  27  instr[26:0] of the held instruction (bit 26 picks beqz/bnez)
//   branch     in  1   conditional-branch strobe
//   jump       in  1   pc-relative jump strobe (j/jal)
//   jar        in  1   register jump strobe (jr/jalr)
//   zero       in  1   ALU result == 0
//   rs1_val    in  32  register target for jr/jalr
//   next_pc    out 32  selected next PC (may be misaligned when rs1_val is)
module dlx_next_pc
  import dlx_pkg::*;
(
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic [26:0]       instr_imm,
  input  logic              branch,
  input  logic              jump,
  input  logic              jar,
  input  logic              zero,
  input  logic [WORD_W-1:0] rs1_val,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] jump_off;
  logic [WORD_W-1:0] branch_off;
  logic              taken;

  assign jump_off   = {{6{instr_imm[25]}}, instr_imm[25:0]};
  assign branch_off = {{16{instr_imm[15]}}, instr_imm[15:0]};

  // beqz (opcode 4) has instr[26]=0 and takes on zero; bnez (opcode 5)
  // has instr[26]=1 and takes on nonzero, so one XOR covers both.
  assign taken = branch & (zero ^ instr_imm[26]);

  // NOTE: next_pc is assigned a default first so no path through this
  // block can leave it unassigned and infer a latch.
  always_comb begin
    next_pc = pc_plus4;
    if (jar) begin
      next_pc = rs1_val;
    end else if (jump) begin
      next_pc = pc_plus4 + jump_off;
    end else if (taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/dlx_ifetch.sv
// dlx_ifetch: DLX instruction-fetch stage. Holds the PC, fetches one word
// per step over a req/ready handshake, presents it to the decoder and
// computes the next PC when the datapath retires the instruction.
// Parameter:
//   RESET_PC     first fetch address after reset (word-aligned)
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   imem_req     out  fetch request, held until imem_ready
//   imem_addr    out  fetch address (= pc)
//   imem_ready   in   imem_rdata valid this cycle
//   imem_rdata   in   fetched word
//   instr        out  instruction presented to the decoder
//   instr_valid  out  instr / pc / pc_plus4 valid
//   pc           out  address of instr
//   pc_plus4     out  pc + 4 (link value)
//   retire       in   datapath done with instr; redirect inputs sampled
//   branch, jump, jar, zero, rs1_val  in  redirect inputs
//   misalign_err out  sticky misaligned-target flag
// Optional feature macro: DLX_IFETCH_ALIGN_CHECK_EN. When defined a
// misaligned next PC parks the stage in ERR until reset; otherwise the
// low two bits of the next PC are cleared and misalign_err is tied low.
module dlx_ifetch
  import dlx_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  input  logic              retire,
  input  logic              branch,
  input  logic              jump,
  input  logic              jar,
  input  logic              zero,
  input  logic [WORD_W-1:0] rs1_val,
  output logic              misalign_err
);

  fetch_state_t      state;
  logic [WORD_W-1:0] next_raw;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  dlx_next_pc u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_imm (instr[26:0]),
    .branch    (branch),
    .jump      (jump),
    .jar       (jar),
    .zero      (zero),
    .rs1_val   (rs1_val),
    .next_pc   (next_raw)
  );

`ifndef DLX_IFETCH_ALIGN_CHECK_EN
  logic [WORD_W-1:0] next_aligned;
  assign next_aligned = next_raw & ~32'd3;
  assign misalign_err = 1'b0;
`endif

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef DLX_IFETCH_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          // imem_req is low only in the first cycle out of reset; any
          // imem_ready seen then belongs to an abandoned request.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (retire) begin
            instr_valid <= 1'b0;
`ifdef DLX_IFETCH_ALIGN_CHECK_EN
            pc <= next_raw;
            if (next_raw[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              state        <= ST_ERR;
            end else begin
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
`else
            pc       <= next_aligned;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
`endif
          end
        end

`ifdef DLX_IFETCH_ALIGN_CHECK_EN
        ST_ERR: begin
          // Parked until reset: no requests, PC keeps the faulting target.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif

        default: begin
          state    <= ST_FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dlx_ifetch.md
# dlx_ifetch

Instruction-fetch stage of the DLX core. Holds the program counter, fetches one 32-bit instruction word per step from instruction memory over a request/ready handshake, and presents it to the instruction decoder. Consumes the decoder's branch/jump/jar strobes, the ALU zero flag and the rs1 value when the datapath retires the instruction, and computes the next PC. Also supplies PC+4 as the link value for jal/jalr.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request, held high until accepted.
- `imem_addr`  out  32  fetch address (current PC), stable while `imem_req` is high.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; ignored unless `imem_req` is high.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction presented to the decoder.
- `instr_valid`  out  1  `instr`, `pc`, `pc_plus4` valid.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, mod 2^32; link value.
- `retire`  in  1  datapath finished `instr`; redirect inputs sampled this cycle.
- `branch`, `jump`, `jar`  in  1 each  control strobes for the held instruction.
- `zero`  in  1  ALU result == 0 for the held instruction.
- `rs1_val`  in  32  register value; jr/jalr target.
- `misalign_err`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: FETCH, HOLD, ERR (ERR exists only with the macro).
- FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ready`: `instr`<=`imem_rdata`, go to HOLD.
- HOLD: `instr_valid`=1, `imem_req`=0. On `retire`: PC<=next_pc, go to FETCH. Without `retire`: hold all outputs.
- next_pc priority: `jar` -> `rs1_val`; else `jump` -> PC+4 + sext(instr[25:0]); else `branch` taken -> PC+4 + sext(instr[15:0]); else PC+4.
- Branch taken: `branch` & (`zero` XOR `instr[26]`). beqz (opcode 4) takes on zero; bnez (opcode 5) takes on nonzero.
- All arithmetic is 32-bit modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `retire` outside HOLD is ignored. `imem_ready` outside FETCH is ignored.
- Reset outputs: PC=`RESET_PC`, state=FETCH, `instr`=0, `instr_valid`=0, `misalign_err`=0.
- `imem_req` goes to 1 on the first cycle after `reset` deasserts.
- Reset asserted mid-fetch abandons the request; a later `imem_ready` for it is ignored.

## Timing
- Zero-wait memory with `retire` asserted in the first HOLD cycle: 2 cycles per instruction (FETCH, HOLD).
- Each memory wait cycle adds one FETCH cycle.
- `instr_valid` rises the cycle after the `imem_ready` handshake.
- New `imem_addr` appears the cycle after `retire`.
- The redirect inputs matter only in the `retire` cycle.

## Configuration
- `DLX_IFETCH_ALIGN_CHECK_EN` defined: if next_pc[1:0]≠0 at `retire`:
  - set `misalign_err`, go to ERR;
  - in ERR: `imem_req`=0, `instr_valid`=0, PC holds the faulting target;
  - only `reset` leaves ERR.
- Macro undefined: next_pc[1:0] forced to 0; ERR state does not exist; `misalign_err` tied to 0.

## Structure
- `dlx_pkg` holds:
  - fetch state enum;
  - opcode constants OP_J=2, OP_JAL=3, OP_BEQZ=4, OP_BNEZ=5, OP_JR=18, OP_JALR=19;
  - `WORD_W`=32.
- Sub-module `dlx_next_pc`: combinational target selection and branch-taken evaluation. The FSM and registers stay in `dlx_ifetch`.

## Test plan
- Reset-release fetch: reset released, `RESET_PC`=0, memory returns 32'h2001_0005 with no wait -> `imem_addr`=0 on the first request; `instr_valid` the next cycle with `pc_plus4`=4.
- Memory wait and sequential step: `imem_ready` delayed 3 cycles -> `imem_req` and `imem_addr` held stable for 3 cycles; `retire` with no redirect -> next `imem_addr`=4.
- Branches at PC=0x100, instr[15:0]=0xFFF0:
  - beqz, `zero`=1 -> next PC 0xF4;
  - beqz, `zero`=0 -> next PC 0x104;
  - bnez, `zero`=0 -> next PC 0xF4.
- Jump and jar priority at PC=0x40:
  - `jump`, instr[25:0]=0x10 -> next PC 0x54;
  - `jar`+`jump` both set, `rs1_val`=0x800 -> next PC 0x800.
- Wrap: PC=0xFFFF_FFFC, sequential `retire` -> `imem_addr`=0.
- Misalignment, with macro: `jar` with `rs1_val`=0x802 -> `misalign_err`=1, no further requests until reset.
- Misalignment, without macro: same stimulus -> fetch from 0x800.
- Reset mid-fetch: reset pulsed during a pending request -> all outputs return to reset values; a stale `imem_ready` is ignored.
